// File: rtl/pscb_gen_tree_pipe_if.sv
// Request/result bus of the pipelined PSCB pass-bit generator tree.
// Member names are seen from the generator: i_* flow into it, o_* flow out.
interface pscb_gen_tree_pipe_if #(
   parameter int INPUTS = 128,
   parameter int DATA_W = 8,
   parameter int TAG_W  = 4
);
   localparam int NODES  = INPUTS / 2;
   localparam int STAGES = $clog2(INPUTS);

   logic                    i_valid;
   logic                    o_ready;
   logic [NODES*STAGES-1:0] i_scb;
   logic [DATA_W-1:0]       i_pass_start;
   logic [DATA_W-1:0]       i_pass_end;
   logic [1:0]              i_mode;
   logic [TAG_W-1:0]        i_tag;
   logic                    o_valid;
   logic                    i_ready;
   logic [NODES*STAGES-1:0] o_pass;
   logic [INPUTS-1:0]       o_mask;
   logic [TAG_W-1:0]        o_tag;
   logic                    o_busy;

   modport master (
      output i_valid, i_scb, i_pass_start, i_pass_end, i_mode, i_tag, i_ready,
      input  o_ready, o_valid, o_pass, o_mask, o_tag, o_busy
   );

   modport slave (
      input  i_valid, i_scb, i_pass_start, i_pass_end, i_mode, i_tag, i_ready,
      output o_ready, o_valid, o_pass, o_mask, o_tag, o_busy
   );
endinterface

// File: rtl/pscb_gen_tree_pipe.sv
// Pipelined PSCB pass-bit generator: builds a line mask, routes it through the
// butterfly stages and emits per-switch pass bits under valid/ready flow control.
module pscb_gen_tree_pipe #(
   parameter int INPUTS      = 128,
   parameter int DATA_W      = 8,
   parameter int PIPE_STRIDE = 1,
   parameter int TAG_W       = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   pscb_gen_tree_pipe_if.slave bus
);
   localparam int NODES  = INPUTS / 2;
   localparam int STAGES = $clog2(INPUTS);
   localparam int RANKS  = (STAGES + PIPE_STRIDE - 1) / PIPE_STRIDE;
   localparam int PW     = NODES * STAGES;

   typedef enum logic [1:0] {
      MODE_UPPER     = 2'b00,
      MODE_LOWER     = 2'b01,
      MODE_RANGE     = 2'b10,
      MODE_INV_RANGE = 2'b11
   } mode_e;

   // Payload of one rank; scb travels with the data so i_scb may change after the handshake.
   typedef struct packed {
      logic [INPUTS-1:0] data;
      logic [PW-1:0]     pass;
      logic [PW-1:0]     scb;
      logic [TAG_W-1:0]  tag;
   } rank_t;

   function automatic logic [INPUTS-1:0] build_mask(input mode_e             mode,
                                                    input logic [DATA_W-1:0] start,
                                                    input logic [DATA_W-1:0] stop);
      logic [INPUTS-1:0] mask;
      logic [DATA_W:0]   line;
      logic              above;
      logic              in_range;
      mask = '0;
      for (int l = 0; l < INPUTS; l++) begin
         line     = (DATA_W+1)'(l);
         above    = line > {1'b0, start};
         in_range = above && (line <= {1'b0, stop});
         case (mode)
            MODE_UPPER: mask[l] = above;
            MODE_LOWER: mask[l] = !above;
            MODE_RANGE: mask[l] = in_range;
            default:    mask[l] = !in_range;
         endcase
      end
      return mask;
   endfunction

   // Apply the stages owned by rank k (highest stage first) to a payload.
   function automatic rank_t run_rank(input rank_t r, input int k);
      rank_t             o;
      logic [INPUTS-1:0] cur;
      int                hi;
      int                lo;
      int                a;
      int                b;
      o  = r;
      hi = STAGES - 1 - k * PIPE_STRIDE;
      lo = hi - PIPE_STRIDE + 1;
      if (lo < 0) lo = 0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         if (s <= hi && s >= lo) begin
            cur = o.data;
            for (int n = 0; n < NODES; n++) begin
               a = ((n >> s) << (s + 1)) | (n & ((1 << s) - 1));
               b = a | (1 << s);
               o.pass[s*NODES + n] = cur[a] | cur[b];
               if (o.scb[s*NODES + n]) begin
                  o.data[a] = cur[b];
                  o.data[b] = cur[a];
               end
            end
         end
      end
      return o;
   endfunction

   rank_t            rank_q [RANKS];
   rank_t            rank_d [RANKS];
   rank_t            req;
   logic [RANKS-1:0] valid_q;
   logic [RANKS-1:0] valid_in;
   logic [RANKS-1:0] adv;
   logic [RANKS:0]   rdy;

   always_comb begin
      req.data = build_mask(mode_e'(bus.i_mode), bus.i_pass_start, bus.i_pass_end);
      req.pass = '0;
      req.scb  = bus.i_scb;
      req.tag  = bus.i_tag;

      rank_d[0]   = run_rank(req, 0);
      valid_in[0] = bus.i_valid;
      for (int k = 1; k < RANKS; k++) begin
         rank_d[k]   = run_rank(rank_q[k-1], k);
         valid_in[k] = valid_q[k-1];
      end

      // Ready ripples backwards from the consumer; a rank moves when empty or drained.
      rdy[RANKS] = bus.i_ready;
      for (int k = RANKS - 1; k >= 0; k--) begin
         adv[k] = !valid_q[k] || rdy[k+1];
         rdy[k] = adv[k];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every rank
   // samples its predecessor's pre-edge value and the pipeline shifts by one rank.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= '0;
         // NOTE: payload is reset too so the result bus reads zero after reset;
         // otherwise it is loaded only on a valid transfer, so bubbles leave it untouched.
         for (int k = 0; k < RANKS; k++) rank_q[k] <= '0;
      end else begin
         for (int k = 0; k < RANKS; k++) begin
            if (adv[k]) begin
               valid_q[k] <= valid_in[k];
               if (valid_in[k]) rank_q[k] <= rank_d[k];
            end
         end
      end
   end

   assign bus.o_ready = adv[0];
   assign bus.o_valid = valid_q[RANKS-1];
   assign bus.o_pass  = rank_q[RANKS-1].pass;
   assign bus.o_mask  = rank_q[RANKS-1].data;
   assign bus.o_tag   = rank_q[RANKS-1].tag;
   assign bus.o_busy  = |valid_q;
endmodule

// File: doc/pscb_gen_tree_pipe.md
Name: pscb_gen_tree_pipe

Overview:
Pipelined, handshaked successor to the combinational pass-bit generator tree for the PSCB butterfly network. It builds a line mask from a selectable mode: upper, lower, range or inverted range. The mask is propagated through STAGES butterfly stages under the supplied switch-control bits (scb), producing per-switch pass bits and the final routed mask. It sits between the page-allocation request logic and the switch-config writer. Register ranks are inserted every PIPE_STRIDE stages, and valid/ready flow control is provided with full throughput.

Parameters:
INPUTS, 128, network line count; power of two, ≥4.
DATA_W, 8, width of start/end indices; must be ≥ $clog2(INPUTS)+1.
PIPE_STRIDE, 1, butterfly stages per register rank; 1..STAGES.
TAG_W, 4, width of the opaque request tag carried alongside data.
NODES (local), INPUTS/2, switches per stage.
STAGES (local), $clog2(INPUTS), number of stages.
RANKS (local), ceil(STAGES/PIPE_STRIDE), number of register ranks; equals latency.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_valid  in  1  request valid
o_ready  out  1  request accepted when i_valid & o_ready
i_scb  in  NODES*STAGES  switch controls; stage s at [s*NODES +: NODES], node n at bit n; 1 = cross
i_pass_start  in  DATA_W  start index
i_pass_end  in  DATA_W  end index (range modes only)
i_mode  in  2  00 upper, 01 lower, 10 range, 11 inverted range
i_tag  in  TAG_W  request tag
o_valid  out  1  result valid
i_ready  in  1  result consumed when o_valid & i_ready
o_pass  out  NODES*STAGES  pass bits, same packing as i_scb
o_mask  out  INPUTS  mask after stage 0
o_tag  out  TAG_W  tag of the result
o_busy  out  1  any rank holds valid data

Behaviour:
- Mask build (input side, combinational, unsigned compare at DATA_W+1 bits, line index L):
  - upper: L > start.
  - lower: L ≤ start.
  - range: start < L ≤ end.
  - inverted range: complement of range.
  - start ≥ INPUTS: upper → all 0, lower → all 1.
  - end ≤ start: range → all 0.
- Stage order: data enters stage STAGES-1 first and exits stage 0.
- Stage s, node n:
  - a = n with a 0 inserted at bit position s; b = a | (1<<s).
  - pass[n] = in[a] | in[b].
  - If scb bit set: out[a] = in[b], out[b] = in[a]. Otherwise out = in.
- Rank k covers PIPE_STRIDE consecutive stages. The last rank holds the remainder.
- Each rank registers: the data vector, the pass bits produced so far, the scb slices for the remaining stages, the tag, and a valid flag.
  - Scb is captured at acceptance, so upstream may change i_scb after the handshake.
- Flow control:
  - rank k advances when !valid_k | ready_{k+1}; ready_{RANKS} = i_ready; o_ready = advance condition of rank 0.
  - No combinational path from i_valid to o_valid.
  - One result per cycle sustained while i_ready=1.
- Latency: exactly RANKS cycles from acceptance to o_valid with no stall.
  - Results emerge in acceptance order, never dropped or duplicated.
- Stall: while o_valid & !i_ready, o_pass, o_mask and o_tag hold stable.
- Reset: all valids clear.
  - o_valid=0, o_busy=0, o_pass=0, o_mask=0, o_tag=0.
  - o_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight requests; no partial result appears.
- Simultaneous accept and emit in the same cycle is legal and required at full throughput.
- i_pass_end is ignored in modes 00/01.

Test Plan:
All scenarios use INPUTS=8, PIPE_STRIDE=1 (RANKS=3).
1. scb=0, mode upper, start=3 → o_mask=8'hF0, o_pass=12'hFCC, o_valid 3 cycles after acceptance.
2. Stage-2 scb=4'hF, others 0, mode upper, start=3 → o_mask=8'h0F, o_pass=12'hF33.
3. scb=0, mode range, start=1, end=5 → o_mask=8'h3C, o_pass=12'hFF6. Repeat with end=1 → o_mask=0, o_pass=0. Repeat with mode 11, start=1, end=5 → o_mask=8'hC3.
4. Boundary indices:
   - upper, start=7 → o_mask=0.
   - lower, start=7 → o_mask=8'hFF.
   - upper, start=200 → o_mask=0.
5. Backpressure: issue tags 1..6 back-to-back with i_ready=0 for 5 cycles, then 1.
   - Exactly 3 accepted before o_ready=0.
   - Outputs hold stable during the stall.
   - Tags emerge 1..6 in order.
   - Then 1 result/cycle.
6. Assert i_rst with 2 requests in flight → next cycle o_valid=0, o_busy=0, o_ready=1. The discarded tags never appear at the output.
